// File: rtl/softmax_classify_ctrl.sv
// Sequencer around the SoftMax output stage: launches one pass, snoops the result
// write port for the argmax, and reports class, probability and an error flag.
module softmax_classify_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DATA_NUM       = 10,
  parameter int unsigned ADR_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_WIDTH       = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_start,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_error,
  output logic [ADR_WIDTH-1:0]  out_class,
  output logic [DATA_WIDTH-1:0] out_maxProb,
  output logic                  sm_start,
  input  logic                  sm_done,
  input  logic                  sm_wr,
  input  logic [ADR_WIDTH-1:0]  sm_adrOut,
  input  logic [DATA_WIDTH-1:0] sm_dataOut
);

  typedef enum logic [1:0] {StIdle, StLaunch, StCollect, StFinish} state_e;

  localparam logic [TO_WIDTH-1:0]  WdLast   = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ADR_WIDTH:0]   NumLim   = (ADR_WIDTH + 1)'(DATA_NUM);
  localparam logic [DATA_NUM-1:0]  MaskFull = {DATA_NUM{1'b1}};

  state_e                state_q, state_d;
  logic [TO_WIDTH-1:0]   wd_q, wd_d;
  logic                  done_prev_q, done_prev_d;
  logic [DATA_NUM-1:0]   mask_q, mask_d;
  logic                  bad_q, bad_d;
  logic                  dup_q, dup_d;
  logic [ADR_WIDTH-1:0]  class_q, class_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_q, start_d;
  logic                  done_edge, wd_expired, adr_ok, take;

  always_comb begin
    done_edge  = sm_done & ~done_prev_q;
    wd_expired = (wd_q == WdLast);
    adr_ok     = ({1'b0, sm_adrOut} < NumLim);
    // Strictly larger wins; on equal values the lower index wins regardless of order.
    take       = (sm_dataOut > max_q) | ((sm_dataOut == max_q) & (sm_adrOut < class_q));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_start) state_d = StLaunch;
      StLaunch:  state_d = StCollect;
      StCollect: if (done_edge || wd_expired) state_d = StFinish;
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Collection datapath
  always_comb begin
    wd_d        = wd_q;
    done_prev_d = done_prev_q;
    mask_d      = mask_q;
    bad_d       = bad_q;
    dup_d       = dup_q;
    class_d     = class_q;
    max_d       = max_q;
    err_d       = err_q;
    if (state_q == StLaunch) begin
      wd_d        = '0;
      done_prev_d = 1'b0;
      mask_d      = '0;
      bad_d       = 1'b0;
      dup_d       = 1'b0;
      class_d     = '0;
      max_d       = '0;
      err_d       = 1'b0;
    end else if (state_q == StCollect) begin
      wd_d        = wd_q + 1'b1;
      done_prev_d = sm_done;
      if (sm_wr) begin
        if (!adr_ok) begin
          bad_d = 1'b1;
        end else begin
          if (mask_q[sm_adrOut]) dup_d = 1'b1;
          mask_d[sm_adrOut] = 1'b1;
          if (take) begin
            max_d   = sm_dataOut;
            class_d = sm_adrOut;
          end
        end
      end
      // A write landing with the done edge must still count toward the error verdict.
      if (state_d == StFinish) begin
        err_d = (wd_expired & ~done_edge) | bad_d | dup_d | (mask_d != MaskFull);
      end
    end
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StFinish);
    start_d = (state_d == StLaunch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q        <= '0;
      done_prev_q <= 1'b0;
      mask_q      <= '0;
      bad_q       <= 1'b0;
      dup_q       <= 1'b0;
      class_q     <= '0;
      max_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      done_prev_q <= done_prev_d;
      mask_q      <= mask_d;
      bad_q       <= bad_d;
      dup_q       <= dup_d;
      class_q     <= class_d;
      max_q       <= max_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_q     <= start_d;
    end
  end

  assign out_busy    = busy_q;
  assign out_done    = done_q;
  assign out_error   = err_q;
  assign out_class   = class_q;
  assign out_maxProb = max_q;
  assign sm_start    = start_q;

endmodule

// File: tb/tb_softmax_classify_ctrl.sv
// Scoreboard bench for softmax_classify_ctrl: directed and random SoftMax passes checked
// against an arithmetic argmax model; a separate monitor checks every completion pulse.
module tb_softmax_classify_ctrl;
  localparam int DW = 32;
  localparam int DN = 10;
  localparam int AW = 4;
  localparam int TO = 16;
  localparam int TW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_start;
  logic          out_busy, out_done, out_error;
  logic [AW-1:0] out_class;
  logic [DW-1:0] out_maxProb;
  logic          sm_start, sm_done, sm_wr;
  logic [AW-1:0] sm_adrOut;
  logic [DW-1:0] sm_dataOut;

  softmax_classify_ctrl #(
    .DATA_WIDTH(DW), .DATA_NUM(DN), .ADR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .out_busy(out_busy), .out_done(out_done),
    .out_error(out_error), .out_class(out_class), .out_maxProb(out_maxProb),
    .sm_start(sm_start), .sm_done(sm_done), .sm_wr(sm_wr), .sm_adrOut(sm_adrOut),
    .sm_dataOut(sm_dataOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic [AW-1:0] cls;
    logic [DW-1:0] maxp;
  } exp_t;

  exp_t          sb_q[$];
  logic [AW-1:0] w_adr[$];
  logic [DW-1:0] w_dat[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            n_sm_start = 0;
  int            exp_starts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: max over valid writes, then the lowest address that carried it.
  function automatic exp_t ref_model(input bit timed_out);
    exp_t          e;
    bit            seen[DN];
    bit            bad = 1'b0;
    bit            dup = 1'b0;
    bit            full = 1'b1;
    logic [DW-1:0] mx = '0;
    int            cls = DN;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < w_adr.size(); i++) begin
      if (int'(w_adr[i]) >= DN) bad = 1'b1;
      else begin
        if (seen[w_adr[i]]) dup = 1'b1;
        seen[w_adr[i]] = 1'b1;
        if (w_dat[i] > mx) mx = w_dat[i];
      end
    end
    for (int i = 0; i < w_adr.size(); i++)
      if (int'(w_adr[i]) < DN && w_dat[i] == mx && int'(w_adr[i]) < cls) cls = int'(w_adr[i]);
    if (mx == '0 || cls == DN) cls = 0;
    foreach (seen[i]) if (!seen[i]) full = 1'b0;
    e.err  = timed_out | bad | dup | !full;
    e.cls  = AW'(cls);
    e.maxp = mx;
    return e;
  endfunction

  // Monitor: every out_done pops one expectation
  initial begin
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (sm_start) n_sm_start++;
      if (out_done) begin
        check("done_single_pulse", 64'(prev), 0);
        check("done_expected", 64'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("out_class", out_class, e.cls);
          check("out_maxProb", out_maxProb, e.maxp);
          check("out_error", out_error, e.err);
        end
      end
      prev = out_done;
    end
  end

  // mode 0: never assert sm_done (timeout); 1: done after writes; 2: done with last write
  task automatic run_txn(input int mode, input bit poke);
    exp_t e;
    int   cyc;
    int   dcyc;
    e = ref_model(mode == 0);
    sb_q.push_back(e);
    exp_starts++;
    @(negedge clk);
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    cyc = 0;
    dcyc = 0;
    check("sm_start_in_launch", sm_start, 1);
    check("busy_in_launch", out_busy, 1);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < w_adr.size(); i++) begin
      sm_wr = 1'b1;
      sm_adrOut = w_adr[i];
      sm_dataOut = w_dat[i];
      if (poke && i == 1) in_start = 1'b1;
      if (mode == 2 && i == w_adr.size() - 1) begin
        sm_done = 1'b1;
        dcyc = cyc;
      end
      @(negedge clk);
      cyc++;
      sm_wr = 1'b0;
      in_start = 1'b0;
      sm_done = 1'b0;
    end
    if (mode == 1) begin
      sm_done = 1'b1;
      dcyc = cyc;
      @(negedge clk);
      cyc++;
      sm_done = 1'b0;
    end
    while (!out_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", out_done, 1);
    if (mode == 0) check("timeout_latency", 64'(cyc), TO + 1);
    else check("done_latency", 64'(cyc), 64'(dcyc + 1));
    @(negedge clk);
    check("idle_after_done", out_busy, 0);
    @(negedge clk);
    check("class_held", out_class, e.cls);
    check("maxp_held", out_maxProb, e.maxp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int perm[DN];
    int n;
    int mode;
    rst = 1'b1; in_start = 1'b0; sm_done = 1'b0; sm_wr = 1'b0;
    sm_adrOut = '0; sm_dataOut = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", out_busy, 0);
    check("rst_done", out_done, 0);
    check("rst_error", out_error, 0);
    check("rst_class", out_class, 0);
    check("rst_maxp", out_maxProb, 0);
    check("rst_sm_start", sm_start, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp
    w_adr.delete(); w_dat.delete();
    for (int i = 0; i < DN; i++) begin
      w_adr.push_back(AW'(i)); w_dat.push_back(DW'(i + 1) << 20);
    end
    run_txn(1, 0);
    check("ramp_class", out_class, 9);
    check("ramp_maxp", out_maxProb, 32'h00A00000);

    // Tie: adr 7 written before adr 2 with the same value
    w_adr.delete(); w_dat.delete();
    w_adr.push_back(AW'(7)); w_dat.push_back(32'h00080000);
    for (int i = 0; i < DN; i++) begin
      if (i == 7) continue;
      w_adr.push_back(AW'(i));
      w_dat.push_back(i == 2 ? 32'h00080000 : DW'(i + 1) << 12);
    end
    run_txn(1, 0);
    check("tie_class", out_class, 2);

    // Timeout with a few writes
    w_adr.delete(); w_dat.delete();
    for (int i = 0; i < 4; i++) begin
      w_adr.push_back(AW'(i)); w_dat.push_back(DW'($urandom_range(1000, 1)));
    end
    run_txn(0, 0);

    // Missing adr 9 plus a bad address
    w_adr.delete(); w_dat.delete();
    for (int i = 0; i < DN - 1; i++) begin
      w_adr.push_back(AW'(i)); w_dat.push_back(DW'($urandom_range(5000, 1)));
    end
    w_adr.push_back(AW'(12)); w_dat.push_back(32'hFFFF_FFFF);
    run_txn(2, 0);

    // Busy poke: second in_start during collection must not relaunch
    w_adr.delete(); w_dat.delete();
    for (int i = DN - 1; i >= 0; i--) begin
      w_adr.push_back(AW'(i)); w_dat.push_back(DW'(DN - i) << 16);
    end
    run_txn(1, 1);

    // Reset mid-collection
    @(negedge clk);
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    exp_starts++;
    @(negedge clk);
    sm_wr = 1'b1; sm_adrOut = AW'(5); sm_dataOut = 32'h00300000;
    @(negedge clk);
    sm_wr = 1'b0;
    check("pre_reset_class", out_class, 5);
    rst = 1'b1;
    #1;
    check("midrst_busy", out_busy, 0);
    check("midrst_class", out_class, 0);
    check("midrst_maxp", out_maxProb, 0);
    check("midrst_sm_start", sm_start, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_done", out_done, 0);
    check("post_rst_error", out_error, 0);

    w_adr.delete(); w_dat.delete();
    for (int i = 0; i < DN; i++) begin
      w_adr.push_back(AW'(i)); w_dat.push_back(DW'(i + 1) << 20);
    end
    run_txn(1, 0);

    // Random passes with ties, omissions, duplicates and bad addresses
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < DN; i++) perm[i] = i;
      for (int i = DN - 1; i > 0; i--) begin
        int j;
        int tmp;
        j = int'($urandom_range(i, 0));
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      n = int'($urandom_range(DN, DN - 2));
      w_adr.delete(); w_dat.delete();
      for (int i = 0; i < n; i++) begin
        w_adr.push_back(AW'(perm[i]));
        w_dat.push_back(DW'($urandom_range(6, 0)) << 18);
      end
      if ($urandom_range(3, 0) == 0) begin
        w_adr.push_back($urandom_range(1, 0) == 1 ? AW'(perm[1]) : AW'($urandom_range(15, DN)));
        w_dat.push_back(DW'($urandom_range(6, 0)) << 18);
      end
      mode = (t == 11) ? 0 : int'($urandom_range(2, 1));
      run_txn(mode, 0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 0);
    check("sm_start_count", 64'(n_sm_start), 64'(exp_starts));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
